// File: rtl/sram_rd_streamer_if.sv
// sp_ram_intf: single-port SRAM port shared between the memory and its compute-side client
interface sp_ram_intf #(
   parameter int ADDR_BUS_WIDTH = 8,
   parameter int DATA_BUS_WIDTH = 32
);
   logic                          en;
   logic [ADDR_BUS_WIDTH-1:0]     addr;
   logic [DATA_BUS_WIDTH/8-1:0]   W_req;
   logic [DATA_BUS_WIDTH-1:0]     W_data;
   logic [DATA_BUS_WIDTH-1:0]     R_data;
   modport compute (output en, addr, W_req, W_data, input R_data);
   modport memory (input en, addr, W_req, W_data, output R_data);
endinterface

// File: rtl/sram_rd_streamer.sv
// sram_rd_streamer: reads a burst of SRAM words and streams them out through a credit-controlled FIFO
module sram_rd_streamer #(
   parameter int FIFO_DEPTH     = 4,
   parameter int LEN_WIDTH      = 16,
   parameter int ADDR_BUS_WIDTH = 8,
   parameter int DATA_BUS_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [ADDR_BUS_WIDTH-1:0] base_addr,
   input  logic [LEN_WIDTH-1:0]      len,
   output logic                      busy,
   output logic                      done,
   sp_ram_intf.compute               ram,
   output logic                      out_valid,
   output logic [DATA_BUS_WIDTH-1:0] out_data,
   output logic                      out_last,
   input  logic                      out_ready
);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;
   logic [1:0]                state, state_nx;
   logic [ADDR_BUS_WIDTH-1:0] base_q, addr_q;
   logic [LEN_WIDTH-1:0]      len_q, issued, xfer;
   logic                      en_q, rd_pend;
   logic [DATA_BUS_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]             wp, rp;
   logic [CW-1:0]             count, count_nx;
   logic [CW:0]               occ;
   logic                      push, pop, accept, issue;
   assign ram.en     = en_q;
   assign ram.addr   = addr_q;
   assign ram.W_req  = '1;
   assign ram.W_data = '0;
   assign out_valid  = count != '0;
   assign out_data   = mem[rp];
   assign out_last   = out_valid && xfer == len_q - LEN_WIDTH'(1);
   assign busy       = state != IDLE;
   assign done       = state == DONE;
   // credit check looks one edge ahead: next FIFO count plus the read currently on the bus
   always_comb begin
      push     = rd_pend;
      pop      = out_valid && out_ready;
      count_nx = count + CW'(push) - CW'(pop);
      occ      = {1'b0, count_nx} + (CW+1)'(en_q);
      accept   = state == IDLE && start;
      issue    = state == RUN && issued < len_q && occ < DEPTH_C;
      state_nx = (state == IDLE)  ? (start ? ((len == '0) ? DONE : RUN) : IDLE) :
                 (state == RUN)   ? ((issued == len_q) ? DRAIN : RUN) :
                 (state == DRAIN) ? ((pop && out_last) ? DONE : DRAIN) : IDLE;
   end
   // burst control, registered read issue and transfer counting
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         base_q  <= '0;
         addr_q  <= '0;
         len_q   <= '0;
         issued  <= '0;
         xfer    <= '0;
         en_q    <= 1'b0;
         rd_pend <= 1'b0;
      end else begin
         state   <= state_nx;
         en_q    <= issue || (accept && len != '0);
         rd_pend <= en_q;
         if (accept) begin
            base_q <= base_addr;
            len_q  <= len;
            xfer   <= '0;
            issued <= (len != '0) ? LEN_WIDTH'(1) : '0;
            if (len != '0) addr_q <= base_addr;
         end
         if (issue) begin
            addr_q <= base_q + ADDR_BUS_WIDTH'(issued);
            issued <= issued + LEN_WIDTH'(1);
         end
         if (pop) xfer <= xfer + LEN_WIDTH'(1);
      end
   end
   // FIFO pointers and occupancy; capture of returning read data is unconditional
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         count <= count_nx;
         if (push) wp <= wp + PW'(1);
         if (pop) rp <= rp + PW'(1);
      end
   end
   // FIFO storage needs no reset; occupancy decides what is valid
   always_ff @(posedge clk) begin
      if (push) mem[wp] <= ram.R_data;
   end
endmodule

// File: doc/sram_rd_streamer.md
Name: sram_rd_streamer

Overview:
- Read-side DMA stage that drives a single-port SRAM through the compute modport of sp_ram_intf.
- On start, it reads len consecutive words from base_addr. Each word passes through a small credit-controlled FIFO and leaves on a valid/ready stream to the conv datapath.
- Hides the 1-cycle SRAM read latency and absorbs downstream backpressure without dropping or re-reading data.

Parameters:
- FIFO_DEPTH, 4, output buffer entries; power of two, minimum 3 for sustained 1 word/cycle.
- LEN_WIDTH, 16, width of the burst length field.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  burst request; accepted only when busy=0.
- base_addr  input  ADDR_BUS_WIDTH  first word address, sampled with an accepted start.
- len  input  LEN_WIDTH  number of words, sampled with an accepted start.
- busy  output  1  high from the cycle after start acceptance until the done cycle, inclusive.
- done  output  1  single-cycle pulse at burst completion.
- ram  interface  sp_ram_intf.compute  SRAM port:
  - drives en, addr, W_req, W_data; receives R_data.
  - en: active-high read enable.
  - W_req: held all-ones, meaning no write lanes active (write lanes are active-low).
  - W_data: held 0.
- out_valid  output  1  out_data/out_last valid.
- out_data  output  DATA_BUS_WIDTH  streamed word; FIFO head.
- out_last  output  1  high with the final word of the burst.
- out_ready  input  1  consumer accept; a transfer occurs when out_valid && out_ready.

Behaviour:
- Reset (async assert, any time including mid-burst):
  - FSM to IDLE.
  - en=0, addr=0, W_req=all-ones, W_data=0.
  - out_valid=0, out_last=0, busy=0, done=0.
  - FIFO emptied; issue, receive and transfer counters cleared.
  - In-flight SRAM data is discarded.
- FSM states:
  - IDLE: start=1 latches base_addr/len and goes to RUN (len=0 goes to DONE instead). start is ignored in every other state.
  - RUN: issues reads until issued==len, then goes to DRAIN.
  - DRAIN: waits until all len words have transferred, then goes to DONE.
  - DONE: done=1, busy=1 for one cycle, then IDLE. A new start is accepted in the following IDLE cycle.
- Read issue, all outputs registered:
  - en=1 in a RUN cycle only when issued<len and (fifo_count + inflight) < FIFO_DEPTH.
  - inflight counts reads whose R_data has not yet been captured (0 or 1).
  - When en=0, addr holds its last value.
- Addressing: addr = base_addr + issued, modulo 2^ADDR_BUS_WIDTH; the address wraps silently.
- SRAM latency: R_data is valid during the cycle after the en=1 cycle and is written into the FIFO at that cycle's closing edge. Capture is unconditional because credit guarantees space.
- Stream:
  - out_valid = FIFO non-empty.
  - out_data is held stable while out_valid && !out_ready.
  - out_last=1 only on the word whose transfer index is len-1.
  - Simultaneous FIFO push and pop in one cycle is allowed; count is unchanged.
- Latency and throughput:
  - start sampled in cycle C0 gives first en=1 in C1, first capture at the end of C2, first out_valid=1 in C3.
  - With out_ready held 1: one word per cycle sustained and no en bubbles after C1.
  - done pulses the cycle after the out_last transfer.
- len=0: no en pulses, no out_valid; done pulses in cycle C1.
- len=1: out_valid and out_last are asserted together.
- Backpressure: en stalls once the FIFO plus in-flight total reaches FIFO_DEPTH and resumes the cycle after a pop frees a credit. No word is lost, duplicated or reordered.
- Counter widths are LEN_WIDTH; maximum burst is 2^LEN_WIDTH-1 words.

Test Plan:
- Basic burst: memory holds addr*3; start base=0x10, len=4, out_ready=1.
  - en high in C1..C4 with addr 0x10..0x13.
  - out_data 0x30, 0x33, 0x36, 0x39 in C3..C6; out_last in C6.
  - done in C7; busy low in C8.
- Backpressure: len=8, out_ready toggling 1,0,0,1 repeated.
  - Exactly 8 transfers in order, with out_data stable during stalls.
  - fifo_count+inflight never exceeds 4; en never asserts when credits are 0.
- Degenerate lengths:
  - len=0 gives no en, no out_valid, done in C1.
  - len=1 gives one transfer with out_last=1 and done the cycle after.
- Wrap-around: base=2^ADDR_BUS_WIDTH-2, len=4 gives addr sequence max-1, max, 0, 1 and matching data.
- Start while busy: a second start with different base/len mid-burst is ignored and the first burst completes unchanged. A start in the first IDLE cycle after done is accepted.
- Reset mid-burst: assert rst asynchronously after 3 transfers of len=10.
  - All outputs take reset values immediately.
  - After release, a fresh len=2 burst produces exactly 2 correct words with no stale data.
